// File: rtl/jpeg_idct_pingpong_ram_if.sv
// Bus bundle for jpeg_idct_pingpong_ram: write side, read side and status.
// The master modport is the client (dequantiser / IDCT pass); the slave modport is the RAM.
// Optional macro JPEG_IDCT_RAM_TRANSPOSE_EN adds the transpose_i read qualifier.
interface jpeg_idct_pingpong_ram_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
);
    logic              wr_valid_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [WIDTH-1:0]  wr_data_i;
    logic              wr_last_i;
    logic              wr_ready_o;
    logic              overflow_o;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_last_i;
    logic              rd_avail_o;
    logic              rd_valid_o;
    logic [WIDTH-1:0]  rd_data_o;
    logic [1:0]        level_o;
`ifdef JPEG_IDCT_RAM_TRANSPOSE_EN
    logic              transpose_i;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_last_i,
        output rd_req_i, rd_addr_i, rd_last_i, transpose_i,
        input  wr_ready_o, overflow_o, rd_avail_o, rd_valid_o, rd_data_o, level_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_last_i,
        input  rd_req_i, rd_addr_i, rd_last_i, transpose_i,
        output wr_ready_o, overflow_o, rd_avail_o, rd_valid_o, rd_data_o, level_o
    );
`else
    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_last_i,
        output rd_req_i, rd_addr_i, rd_last_i,
        input  wr_ready_o, overflow_o, rd_avail_o, rd_valid_o, rd_data_o, level_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_last_i,
        input  rd_req_i, rd_addr_i, rd_last_i,
        output wr_ready_o, overflow_o, rd_avail_o, rd_valid_o, rd_data_o, level_o
    );
`endif
endinterface

// File: rtl/jpeg_idct_pingpong_ram.sv
// Double-buffered (ping-pong) block store for the IDCT path.
// The writer fills one bank while the reader drains the other; a bank changes
// hands only through commit (wr_last_i) and release (rd_last_i), so an unread
// block is never overwritten. Storage is not reset; only pointers and flags are.
// Optional macro JPEG_IDCT_RAM_TRANSPOSE_EN: swaps the row/column halves of the
// read address when transpose_i is set (ADDR_W must then be even).
module jpeg_idct_pingpong_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    jpeg_idct_pingpong_ram_if.slave  bus
);

    localparam int DEPTH  = 2 ** (ADDR_W + 1);
    localparam int HALF_W = ADDR_W / 2;

    // Bank pointers, committed-bank flags and registered outputs
    logic              wr_bank_q;
    logic              rd_bank_q;
    logic [1:0]        full_q;
    logic              rd_valid_r;
    logic [WIDTH-1:0]  rd_data_r;
    logic              overflow_r;

    // Both banks in one array, bank select is the address MSB
    logic [WIDTH-1:0]  mem_r [DEPTH];

    logic              wr_ready_s;
    logic              rd_avail_s;
    logic              wr_accept_s;
    logic              wr_drop_s;
    logic              rd_accept_s;
    logic [1:0]        full_set_s;
    logic [1:0]        full_clr_s;
    logic [ADDR_W-1:0] phys_addr_s;
    logic [1:0]        level_s;

    // Handshake decode: bank status, accepts and flag set/clear masks
    always_comb begin
        wr_ready_s  = ~full_q[wr_bank_q];
        rd_avail_s  = full_q[rd_bank_q];
        wr_accept_s = bus.wr_valid_i & wr_ready_s;
        wr_drop_s   = bus.wr_valid_i & ~wr_ready_s;
        rd_accept_s = bus.rd_req_i & rd_avail_s;
        full_set_s  = 2'b00;
        full_clr_s  = 2'b00;
        if (wr_accept_s && bus.wr_last_i) begin
            full_set_s = wr_bank_q ? 2'b10 : 2'b01;
        end else begin
            full_set_s = 2'b00;
        end
        if (rd_accept_s && bus.rd_last_i) begin
            full_clr_s = rd_bank_q ? 2'b10 : 2'b01;
        end else begin
            full_clr_s = 2'b00;
        end
        level_s = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    end

    // Physical read address, optionally transposed for the column pass
    always_comb begin
        phys_addr_s = bus.rd_addr_i;
`ifdef JPEG_IDCT_RAM_TRANSPOSE_EN
        if (bus.transpose_i) begin
            phys_addr_s = {bus.rd_addr_i[HALF_W-1:0], bus.rd_addr_i[ADDR_W-1:HALF_W]};
        end else begin
            phys_addr_s = bus.rd_addr_i;
        end
`endif
    end

    // Bank pointers and committed flags; commit and release hit different banks
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
        end else begin
            full_q <= (full_q | full_set_s) & ~full_clr_s;
            if (wr_accept_s && bus.wr_last_i) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (rd_accept_s && bus.rd_last_i) begin
                rd_bank_q <= ~rd_bank_q;
            end
        end
    end

    // Registered read port and overflow pulse; data holds when no read is accepted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_accept_s;
            overflow_r <= wr_drop_s;
            if (rd_accept_s) begin
                rd_data_r <= mem_r[{rd_bank_q, phys_addr_s}];
            end
        end
    end

    // Storage write into the current write bank; contents survive reset
    always_ff @(posedge clk_i) begin
        if (wr_accept_s) begin
            mem_r[{wr_bank_q, bus.wr_addr_i}] <= bus.wr_data_i;
        end
    end

    assign bus.wr_ready_o = wr_ready_s;
    assign bus.rd_avail_o = rd_avail_s;
    assign bus.level_o    = level_s;
    assign bus.rd_valid_o = rd_valid_r;
    assign bus.rd_data_o  = rd_data_r;
    assign bus.overflow_o = overflow_r;

endmodule
